// File: rtl/rr_mux_arb.sv
// N:1 valid/ready selector with internal round-robin or fixed-priority arbitration,
// feeding a one-entry output register that reports the source channel index.
module rr_mux_arb #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 3,
  parameter int SELW   = (NUM_IN <= 2) ? 1 : $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pri_mode,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SELW-1:0]         out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [SELW-1:0]   r_last;
  logic [WIDTH-1:0]  r_data;
  logic [SELW-1:0]   r_sel;
  logic              r_valid;

  logic [NUM_IN-1:0] w_grant;
  logic [SELW-1:0]   w_gidx;
  logic              w_found;
  logic              w_load;
  logic [WIDTH-1:0]  w_gdata;

  always_comb begin
    int c;
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    c       = 0;
    if (pri_mode) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (in_valid[i]) begin
          w_gidx  = SELW'(i);
          w_found = 1'b1;
        end
      end
    end else begin
      // Scan last+1, last+2, ... with wrap; only constant bit selects on in_valid.
      for (int k = 1; k <= NUM_IN; k++) begin
        c = int'(r_last) + k;
        if (c >= NUM_IN) c = c - NUM_IN;
        for (int i = 0; i < NUM_IN; i++) begin
          if (!w_found && (i == c) && in_valid[i]) begin
            w_gidx  = SELW'(i);
            w_found = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_found && (w_gidx == SELW'(i))) w_grant[i] = 1'b1;
    end
  end

  always_comb begin
    w_gdata = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_gidx == SELW'(i)) w_gdata = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign w_load   = !reset && (|in_valid) && (!r_valid || out_ready);
  assign in_ready = w_load ? w_grant : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_last  <= SELW'(NUM_IN - 1);
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_gdata;
      r_sel   <= w_gidx;
      r_last  <= w_gidx;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed plan steps plus randomized traffic, checked against a behavioural model.
module tb_rr_mux_arb;
  localparam int W = 8;
  localparam int N = 3;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           pri_mode;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_valid;
  logic           out_ready;

  rr_mux_arb #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk(clk), .reset(reset), .pri_mode(pri_mode), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [W-1:0] d [N];
  bit           m_ov;
  logic [W-1:0] m_od;
  int           m_os;
  int           m_last;
  logic [N-1:0] m_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Winner by the arbitration rules: highest requester, or first requester after last.
  function automatic int model_grant(logic [N-1:0] v, bit pm, int last);
    if (pm) begin
      for (int i = N - 1; i >= 0; i--) if (v[i]) return i;
      return -1;
    end
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic step(input string tag);
    int  g;
    bit  ld;
    in_data = {d[2], d[1], d[0]};
    #1;
    g  = model_grant(in_valid, pri_mode, m_last);
    ld = !reset && (g >= 0) && (!m_ov || out_ready);
    m_rdy = '0;
    if (ld) m_rdy[g] = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_rdy));
    @(posedge clk);
    if (reset) begin
      m_ov = 0; m_od = '0; m_os = 0; m_last = N - 1;
    end else if (ld) begin
      m_ov = 1; m_od = d[g]; m_os = g; m_last = g;
    end else if (out_ready) begin
      m_ov = 0;
    end
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".out_data"},  32'(out_data),  32'(m_od));
    chk({tag, ".out_sel"},   32'(out_sel),   32'(m_os));
  endtask

  initial begin
    logic [W-1:0] exp_d [N];
    logic [N-1:0] pend;
    exp_d[0] = 8'hA0; exp_d[1] = 8'hB1; exp_d[2] = 8'hC2;
    d[0] = 8'hA0; d[1] = 8'hB1; d[2] = 8'hC2;
    m_ov = 0; m_od = '0; m_os = 0; m_last = N - 1; m_rdy = '0;
    reset = 1; pri_mode = 0; in_valid = 3'b111; out_ready = 1;
    in_data = {d[2], d[1], d[0]};

    step("rst0");
    step("rst1");
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data",  32'(out_data),  32'd0);
    reset = 0;

    // Round-robin with all channels requesting
    for (int i = 0; i < 6; i++) begin
      step("rr_all");
      chk("rr_seq.sel",  32'(out_sel),  32'(i % 3));
      chk("rr_seq.data", 32'(out_data), 32'(exp_d[i % 3]));
    end

    // Fixed priority
    pri_mode = 1;
    for (int i = 0; i < 6; i++) begin
      #1 chk("pri.in_ready", 32'(in_ready), 32'b100);
      step("pri_all");
      chk("pri.sel",  32'(out_sel),  32'd2);
      chk("pri.data", 32'(out_data), 32'hC2);
    end

    // Stall
    pri_mode = 0; in_valid = 3'b001;
    step("stall_load");
    chk("stall_load.data", 32'(out_data), 32'hA0);
    out_ready = 0; in_valid = 3'b110;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall.in_ready", 32'(in_ready), 32'd0);
      step("stall");
      chk("stall.data", 32'(out_data), 32'hA0);
      chk("stall.sel",  32'(out_sel),  32'd0);
    end
    out_ready = 1;
    step("stall_release");
    chk("stall_release.sel",  32'(out_sel),  32'd1);
    chk("stall_release.data", 32'(out_data), 32'hB1);

    // Sparse round-robin, last=1
    in_valid = 3'b001;
    step("sparse0");
    chk("sparse0.sel", 32'(out_sel), 32'd0);
    in_valid = 3'b011;
    step("sparse1");
    chk("sparse1.sel", 32'(out_sel), 32'd1);
    in_valid = 3'b000;
    step("idle0");
    step("idle1");
    chk("idle.out_valid", 32'(out_valid), 32'd0);
    in_valid = 3'b111;
    step("after_idle");
    chk("after_idle.sel", 32'(out_sel), 32'd2);

    // Reset mid-operation
    step("pre_rst0");
    step("pre_rst1");
    chk("pre_rst.data", 32'(out_data), 32'hB1);
    reset = 1;
    #1 chk("rst_mid.in_ready", 32'(in_ready), 32'd0);
    step("rst_mid");
    chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid.out_data",  32'(out_data),  32'd0);
    chk("rst_mid.out_sel",   32'(out_sel),   32'd0);
    reset = 0;
    step("post_rst");
    chk("post_rst.sel", 32'(out_sel), 32'd0);

    // Mode switch mid-stream
    pri_mode = 1; in_valid = 3'b011;
    step("sw_pri");
    chk("sw_pri.sel", 32'(out_sel), 32'd1);
    pri_mode = 0;
    step("sw_rr");
    chk("sw_rr.sel", 32'(out_sel), 32'd0);

    // Randomized traffic; producers hold valid and data until accepted
    pend = 3'b000;
    for (int c = 0; c < N; c++) d[c] = W'($urandom);
    for (int t = 0; t < 400; t++) begin
      in_valid  = pend;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) pri_mode = ~pri_mode;
      reset = ($urandom_range(0, 59) == 0);
      step("rand");
      for (int c = 0; c < N; c++) begin
        if (m_rdy[c]) pend[c] = 1'b0;
        if (!pend[c] && $urandom_range(0, 2) != 0) begin
          pend[c] = 1'b1;
          d[c] = W'($urandom);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
